// File: rtl/pipeline_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline: tracks in-flight writers ahead of ID,
// raises load-use stalls and branch flushes, and registers per-operand forwarding selects for EX.
module pipeline_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int BR_STAGE = 2,
    parameter int CNT_W    = 16,
    localparam int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_id_rs_used,
    input  logic              i_id_rt_used,
    input  logic [REG_AW-1:0] i_id_dest,
    input  logic              i_id_regwrite,
    input  logic              i_id_memread,
    input  logic              i_branch_taken,
    output logic              o_stall,
    output logic              o_flush,
    output logic [SEL_W-1:0]  o_fwd_rs,
    output logic [SEL_W-1:0]  o_fwd_rt,
    output logic [CNT_W-1:0]  o_stall_count
);

    logic              r_valid    [1:DEPTH];
    logic [REG_AW-1:0] r_dest     [1:DEPTH];
    logic              r_regwrite [1:DEPTH];
    logic              r_memread  [1:DEPTH];

    logic [SEL_W-1:0]  r_fwd_rs;
    logic [SEL_W-1:0]  r_fwd_rt;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [SEL_W-1:0]  w_sel_rs;
    logic [SEL_W-1:0]  w_sel_rt;
    logic              w_haz_rs;
    logic              w_haz_rt;
    logic              w_stall;
    logic              w_enter;

    // Scan oldest to youngest so the smallest matching entry (youngest writer) wins.
    always_comb begin
        w_sel_rs = '0;
        w_sel_rt = '0;
        w_haz_rs = 1'b0;
        w_haz_rt = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (r_valid[k] && r_regwrite[k] && i_id_rs_used &&
                (i_id_rs != '0) && (r_dest[k] == i_id_rs)) begin
                w_sel_rs = SEL_W'(k);
                w_haz_rs = r_memread[k] && (k < LOAD_LAT);
            end
            if (r_valid[k] && r_regwrite[k] && i_id_rt_used &&
                (i_id_rt != '0) && (r_dest[k] == i_id_rt)) begin
                w_sel_rt = SEL_W'(k);
                w_haz_rt = r_memread[k] && (k < LOAD_LAT);
            end
        end
    end

    assign w_stall       = i_id_valid & (w_haz_rs | w_haz_rt) & ~i_branch_taken;
    assign w_enter       = i_id_valid & ~w_stall & ~i_branch_taken;
    assign o_stall       = w_stall;
    assign o_flush       = i_branch_taken;
    assign o_fwd_rs      = r_fwd_rs;
    assign o_fwd_rt      = r_fwd_rt;
    assign o_stall_count = r_stall_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid[1]    <= 1'b0;
            r_dest[1]     <= '0;
            r_regwrite[1] <= 1'b0;
            r_memread[1]  <= 1'b0;
        end else begin
            r_valid[1]    <= w_enter;
            r_dest[1]     <= i_id_dest;
            r_regwrite[1] <= i_id_regwrite;
            r_memread[1]  <= i_id_memread;
        end
    end

    genvar gi;
    generate
        for (gi = 2; gi <= DEPTH; gi++) begin : g_shift
            logic w_kill;
            // Entries younger than the resolving branch are wrong-path and die on a taken branch.
            if (gi < BR_STAGE) begin : g_wrong_path
                assign w_kill = i_branch_taken;
            end else begin : g_keep
                assign w_kill = 1'b0;
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_valid[gi]    <= 1'b0;
                    r_dest[gi]     <= '0;
                    r_regwrite[gi] <= 1'b0;
                    r_memread[gi]  <= 1'b0;
                end else begin
                    r_valid[gi]    <= r_valid[gi-1] & ~w_kill;
                    r_dest[gi]     <= r_dest[gi-1];
                    r_regwrite[gi] <= r_regwrite[gi-1];
                    r_memread[gi]  <= r_memread[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fwd_rs <= '0;
            r_fwd_rt <= '0;
        end else if (w_enter) begin
            r_fwd_rs <= w_sel_rs;
            r_fwd_rt <= w_sel_rt;
        end else begin
            r_fwd_rs <= '0;
            r_fwd_rt <= '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scenario bench for pipeline_hazard_unit: forwarding selects go through an expectation queue
// and are compared the cycle after each ID instruction is presented.
module tb_pipeline_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, rs_used, rt_used, regwrite, memread, br;
    logic [4:0] rs, rt, dest;

    logic        stall, flush, stall_s, flush_s;
    logic [1:0]  fwd_rs, fwd_rt, fwd_rs_s, fwd_rt_s;
    logic [15:0] cnt;
    logic [1:0]  cnt_s;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp;

    always #5 clk = ~clk;

    pipeline_hazard_unit u_dut (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_rs(rs), .i_id_rt(rt),
        .i_id_rs_used(rs_used), .i_id_rt_used(rt_used), .i_id_dest(dest),
        .i_id_regwrite(regwrite), .i_id_memread(memread), .i_branch_taken(br),
        .o_stall(stall), .o_flush(flush), .o_fwd_rs(fwd_rs), .o_fwd_rt(fwd_rt),
        .o_stall_count(cnt)
    );

    pipeline_hazard_unit #(.CNT_W(2)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_rs(rs), .i_id_rt(rt),
        .i_id_rs_used(rs_used), .i_id_rt_used(rt_used), .i_id_dest(dest),
        .i_id_regwrite(regwrite), .i_id_memread(memread), .i_branch_taken(br),
        .o_stall(stall_s), .o_flush(flush_s), .o_fwd_rs(fwd_rs_s), .o_fwd_rt(fwd_rt_s),
        .o_stall_count(cnt_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] s, input logic [4:0] t,
                         input logic su, input logic tu, input logic [4:0] d,
                         input logic rw, input logic mr, input logic b);
        id_valid = v; rs = s; rt = t; rs_used = su; rt_used = tu;
        dest = d; regwrite = rw; memread = mr; br = b;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", flush); end
        total++; if ({fwd_rs, fwd_rt} !== 4'h0) begin bad++; $display("FAIL reset_fwd got=%h want=0", {fwd_rs, fwd_rt}); end
        total++; if (cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_forward();
        idle(3);
        drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);                 // add $3,$1,$2
        exp_q.push_back({2'd0, 2'd0}); #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL fwd_add_stall got=%b want=0", stall); end
        tick(); exp = exp_q.pop_front();
        total++; if ({fwd_rs, fwd_rt} !== exp) begin bad++; $display("FAIL fwd_add got=%h want=%h", {fwd_rs, fwd_rt}, exp); end
        $display("txn add: fwd_rs=%0d fwd_rt=%0d", fwd_rs, fwd_rt);
        drive(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0);                 // sub $4,$3,$5
        exp_q.push_back({2'd1, 2'd0}); #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL fwd_sub_stall got=%b want=0", stall); end
        tick(); exp = exp_q.pop_front();
        total++; if ({fwd_rs, fwd_rt} !== exp) begin bad++; $display("FAIL fwd_sub got=%h want=%h", {fwd_rs, fwd_rt}, exp); end
        $display("txn sub: fwd_rs=%0d fwd_rt=%0d", fwd_rs, fwd_rt);
    endtask

    task automatic test_load_use();
        idle(3);
        drive(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0);                 // lw $2,0($1)
        exp_q.push_back(4'h0); #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_lw_stall got=%b want=0", stall); end
        tick(); exp = exp_q.pop_front();
        total++; if ({fwd_rs, fwd_rt} !== exp) begin bad++; $display("FAIL lu_lw got=%h want=%h", {fwd_rs, fwd_rt}, exp); end
        drive(1, 5'd2, 5'd2, 1, 1, 5'd4, 1, 0, 0);                 // add $4,$2,$2
        exp_q.push_back(4'h0); #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b want=1", stall); end
        tick(); exp = exp_q.pop_front();
        total++; if ({fwd_rs, fwd_rt} !== exp) begin bad++; $display("FAIL lu_bubble got=%h want=%h", {fwd_rs, fwd_rt}, exp); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_release got=%b want=0", stall); end
        exp_q.push_back({2'd2, 2'd2});
        tick(); exp = exp_q.pop_front();
        total++; if ({fwd_rs, fwd_rt} !== exp) begin bad++; $display("FAIL lu_fwd got=%h want=%h", {fwd_rs, fwd_rt}, exp); end
        total++; if (cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", cnt); end
        $display("txn lw/add: fwd_rs=%0d fwd_rt=%0d count=%0d", fwd_rs, fwd_rt, cnt);
    endtask

    task automatic test_youngest();
        idle(3);
        drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
        exp_q.push_back(4'h0); tick(); exp = exp_q.pop_front();
        total++; if ({fwd_rs, fwd_rt} !== exp) begin bad++; $display("FAIL yw_first got=%h want=%h", {fwd_rs, fwd_rt}, exp); end
        drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
        exp_q.push_back(4'h0); tick(); exp = exp_q.pop_front();
        total++; if ({fwd_rs, fwd_rt} !== exp) begin bad++; $display("FAIL yw_second got=%h want=%h", {fwd_rs, fwd_rt}, exp); end
        drive(1, 5'd3, 5'd0, 1, 1, 5'd6, 1, 0, 0);                 // or $6,$3,$0
        exp_q.push_back({2'd1, 2'd0}); #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL yw_stall got=%b want=0", stall); end
        tick(); exp = exp_q.pop_front();
        total++; if ({fwd_rs, fwd_rt} !== exp) begin bad++; $display("FAIL yw_or got=%h want=%h", {fwd_rs, fwd_rt}, exp); end
        $display("txn or: fwd_rs=%0d fwd_rt=%0d", fwd_rs, fwd_rt);
    endtask

    task automatic test_zero_reg();
        idle(3);
        drive(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0);                 // lw $0,0($1)
        exp_q.push_back(4'h0); tick(); exp = exp_q.pop_front();
        total++; if ({fwd_rs, fwd_rt} !== exp) begin bad++; $display("FAIL z_lw got=%h want=%h", {fwd_rs, fwd_rt}, exp); end
        drive(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0, 0);
        exp_q.push_back(4'h0); #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL z_stall got=%b want=0", stall); end
        tick(); exp = exp_q.pop_front();
        total++; if ({fwd_rs, fwd_rt} !== exp) begin bad++; $display("FAIL z_fwd got=%h want=%h", {fwd_rs, fwd_rt}, exp); end
        $display("txn reader $0: fwd_rs=%0d fwd_rt=%0d", fwd_rs, fwd_rt);
    endtask

    task automatic test_idle_no_hazard();
        idle(3);
        drive(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);                 // lw $5
        exp_q.push_back(4'h0); tick(); exp = exp_q.pop_front();
        drive(0, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0, 0);                 // invalid reader of $5
        exp_q.push_back(4'h0); #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL idle_stall got=%b want=0", stall); end
        tick(); exp = exp_q.pop_front();
        total++; if ({fwd_rs, fwd_rt} !== exp) begin bad++; $display("FAIL idle_fwd got=%h want=%h", {fwd_rs, fwd_rt}, exp); end
        $display("txn idle: fwd_rs=%0d fwd_rt=%0d", fwd_rs, fwd_rt);
    endtask

    task automatic test_branch_flush();
        idle(3);
        drive(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0);                 // lw $2
        exp_q.push_back(4'h0); tick(); exp = exp_q.pop_front();
        drive(1, 5'd2, 5'd2, 1, 1, 5'd4, 1, 0, 1);                 // add $4,$2,$2 with taken branch
        exp_q.push_back(4'h0); #1;
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL br_flush got=%b want=1", flush); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL br_stall got=%b want=0", stall); end
        tick(); exp = exp_q.pop_front();
        total++; if ({fwd_rs, fwd_rt} !== exp) begin bad++; $display("FAIL br_fwd got=%h want=%h", {fwd_rs, fwd_rt}, exp); end
        total++; if (cnt !== 16'd1) begin bad++; $display("FAIL br_cnt got=%0d want=1", cnt); end
        drive(1, 5'd4, 5'd2, 1, 1, 5'd7, 1, 0, 0);                 // or $7,$4,$2: killed add must not forward
        exp_q.push_back({2'd0, 2'd2}); #1;
        total++; if ({stall, flush} !== 2'b00) begin bad++; $display("FAIL br_after got=%b want=00", {stall, flush}); end
        tick(); exp = exp_q.pop_front();
        total++; if ({fwd_rs, fwd_rt} !== exp) begin bad++; $display("FAIL br_wrongpath got=%h want=%h", {fwd_rs, fwd_rt}, exp); end
        $display("txn branch: fwd_rs=%0d fwd_rt=%0d count=%0d", fwd_rs, fwd_rt, cnt);
    endtask

    task automatic test_reset_mid();
        idle(3);
        drive(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0);
        exp_q.push_back(4'h0); tick(); exp = exp_q.pop_front();
        drive(1, 5'd2, 5'd2, 1, 1, 5'd4, 1, 0, 0);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL rm_pre got=%b want=1", stall); end
        rst = 1'b1; #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rm_stall got=%b want=0", stall); end
        total++; if (cnt !== 16'd0) begin bad++; $display("FAIL rm_cnt got=%0d want=0", cnt); end
        tick();
        rst = 1'b0; #1;
        exp_q.push_back(4'h0);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rm_post_stall got=%b want=0", stall); end
        tick(); exp = exp_q.pop_front();
        total++; if ({fwd_rs, fwd_rt} !== exp) begin bad++; $display("FAIL rm_fwd got=%h want=%h", {fwd_rs, fwd_rt}, exp); end
        $display("txn reset-mid: fwd_rs=%0d fwd_rt=%0d count=%0d", fwd_rs, fwd_rt, cnt);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            idle(1);
            drive(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0);
            exp_q.push_back(4'h0); tick(); exp = exp_q.pop_front();
            drive(1, 5'd2, 5'd2, 1, 1, 5'd4, 1, 0, 0);
            exp_q.push_back(4'h0); #1;
            total++; if (stall !== 1'b1) begin bad++; $display("FAIL sat_stall%0d got=%b want=1", i, stall); end
            tick(); exp = exp_q.pop_front();
            exp_q.push_back({2'd2, 2'd2});
            tick(); exp = exp_q.pop_front();
            total++; if ({fwd_rs, fwd_rt} !== exp) begin bad++; $display("FAIL sat_fwd%0d got=%h want=%h", i, {fwd_rs, fwd_rt}, exp); end
            if (i == 1) begin
                total++; if (cnt_s !== 2'd2) begin bad++; $display("FAIL sat_mid got=%0d want=2", cnt_s); end
            end
            $display("txn stall %0d: count=%0d small_count=%0d", i, cnt, cnt_s);
        end
        total++; if (cnt_s !== 2'd3) begin bad++; $display("FAIL sat_small got=%0d want=3", cnt_s); end
        total++; if (cnt !== 16'd5) begin bad++; $display("FAIL sat_wide got=%0d want=5", cnt); end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_forward();
        test_load_use();
        test_youngest();
        test_zero_reg();
        test_idle_no_hazard();
        test_branch_flush();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
